bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
Multi-digit BCD up/down counter with a time-multiplexed digit scanner. It sits directly upstream of the BCD-to-7-segment decoder. Each cycle it presents one BCD nibble on o_bcd, which drives decoder i_A..i_D, together with a one-hot digit-enable on o_dig_sel. Scanning the digits in turn lets one decoder drive a NUM_DIGITS-digit display.

Parameters:
NUM_DIGITS, 4, number of BCD digits; legal range 1..8
SCAN_DIV, 4, clock cycles each digit stays selected; legal range >= 1

Ports:
i_clk  input  1  single clock; all state updates on the rising edge
i_rst  input  1  synchronous, active-high reset
i_en  input  1  count enable
i_up  input  1  direction: 1 = increment, 0 = decrement
i_load  input  1  load request
i_load_val  input  4*NUM_DIGITS  BCD load value; digit 0 in bits [3:0]
o_count  output  4*NUM_DIGITS  current BCD count; digit 0 in bits [3:0]
o_bcd  output  4  nibble of the selected digit; bit3 -> decoder i_A, bit0 -> decoder i_D
o_dig_sel  output  NUM_DIGITS  one-hot digit enable; bit k = digit k
o_carry  output  1  one-cycle pulse on wrap (up) or borrow-out (down)
o_load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- One clock. Reset is synchronous and active-high: sampled on the i_clk rising edge.
- Reset values: o_count = 0, scan index = 0, o_dig_sel = 1 (digit 0), o_bcd = 0, o_carry = 0, o_load_err = 0, prescaler = 0.
- Count-register priority per edge: i_rst > i_load > i_en. When i_en = 0 and i_load = 0, the count holds.
- Load, all nibbles of i_load_val <= 9:
  - o_count = i_load_val on the next edge.
  - o_carry = 0, o_load_err = 0.
- Load, any nibble > 9:
  - count unchanged.
  - o_load_err = 1 for exactly one cycle.
  - counting is suppressed that cycle even if i_en = 1.
- Count up, i_en = 1 and i_load = 0:
  - digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - all-9s goes to all-0s with o_carry = 1 in the same cycle o_count shows zero.
- Count down:
  - digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - all-0s goes to all-9s with o_carry = 1.
- o_carry and o_load_err are registered and last one cycle; otherwise they are 0.
- Count latency: 1 cycle from the sampled i_en/i_load to the o_count update.
- Prescaler:
  - free-running 0..SCAN_DIV-1, not gated by i_en or i_load.
  - on the edge where it is at SCAN_DIV-1, it returns to 0 and the scan index advances modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - with SCAN_DIV = 1 the index advances every cycle.
- o_dig_sel is the one-hot decode of the scan index. Exactly one bit is high at all times, including the cycle after reset.
- o_bcd = o_count[4*idx +: 4]. It is derived only from registered state (glitch-free), so a count update shows on o_bcd in the same cycle o_count changes.
- Loads and counting never disturb the scan index or prescaler.
- Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Reset asserted mid-count or mid-scan: every register takes its reset value on that edge; i_load and i_en are ignored that cycle.
- o_bcd is never > 9, so the downstream decoder only sees legal codes.

Test Plan:
- Reset, then i_en = 1, i_up = 1 for 12 cycles -> o_count = 16'h0012, o_carry stays 0.
- Load 16'h9998 (1 cycle), then i_en = 1, i_up = 1 for 2 cycles -> o_count = 16'h9999, then 16'h0000 with o_carry = 1 for that cycle only.
- Load 16'h0001, then i_en = 1, i_up = 0 for 2 cycles -> 16'h0000 (o_carry = 0), then 16'h9999 (o_carry = 1).
- Load 16'h12A4 with i_en = 1 -> o_load_err = 1 for one cycle, o_count unchanged, no count step that cycle.
- Load 16'h4321, i_en = 0, SCAN_DIV = 4 -> o_dig_sel/o_bcd sequence 0001/1, 0010/2, 0100/3, 1000/4, each held 4 cycles, then back to 0001/1. With o_bcd driving the decoder, the segments are 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110 in order.
- i_load and i_en asserted together -> load wins.
- i_rst asserted mid-count with i_en = 1 -> next edge o_count = 0, o_dig_sel = 0001, o_carry = 0.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a one-hot, time-multiplexed digit scanner
// that feeds a single downstream BCD-to-7-segment decoder.
module bcd_scan_counter #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_up,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_load_val,
    output logic [4*NUM_DIGITS-1:0] o_count,
    output logic [3:0]              o_bcd,
    output logic [NUM_DIGITS-1:0]   o_dig_sel,
    output logic                    o_carry,
    output logic                    o_load_err
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [W-1:0]  r_count;
    logic          r_carry;
    logic          r_load_err;
    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;

    logic [W-1:0]  w_step;
    logic          w_ripple;
    logic [3:0]    w_dig;
    logic          w_load_ok;
    logic [3:0]    w_bcd;
    logic [NUM_DIGITS-1:0] w_sel;

    // w_ripple is the carry/borrow running through the digits; if it survives
    // the last digit the whole counter wrapped.
    always_comb begin
        w_step   = r_count;
        w_ripple = 1'b1;
        w_dig    = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (w_ripple) begin
                if (i_up) begin
                    if (w_dig == 4'd9) begin
                        w_step[4*k +: 4] = 4'd0;
                    end else begin
                        w_step[4*k +: 4] = w_dig + 4'd1;
                        w_ripple = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_step[4*k +: 4] = 4'd9;
                    end else begin
                        w_step[4*k +: 4] = w_dig - 4'd1;
                        w_ripple = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_ok = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_load_val[4*k +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // Digit mux and select decode come only from registers, so they are glitch-free.
    always_comb begin
        w_bcd = 4'd0;
        w_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_bcd    = r_count[4*k +: 4];
                w_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
            r_presc    <= '0;
            r_idx      <= '0;
        end else begin
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
            if (i_load) begin
                if (w_load_ok) begin
                    r_count <= i_load_val;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (i_en) begin
                r_count <= w_step;
                r_carry <= w_ripple;
            end

            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_bcd      = w_bcd;
    assign o_dig_sel  = w_sel;
    assign o_carry    = r_carry;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised bench for bcd_scan_counter: an integer-valued reference model plus
// a cycle counter predicts count, scan position, digit, carry and load-error.
module tb_bcd_scan_counter;

    localparam int N    = 4;
    localparam int SD   = 4;
    localparam int MAXV = 9999;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           up;
    logic           load;
    logic [4*N-1:0] load_val;
    logic [4*N-1:0] count;
    logic [3:0]     bcd;
    logic [N-1:0]   dig_sel;
    logic           carry;
    logic           load_err;

    int n_vec = 0;
    int n_err = 0;

    int m_val   = 0;
    bit m_carry = 1'b0;
    bit m_err   = 1'b0;
    int m_tick  = 0;

    bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_up       (up),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count),
        .o_bcd      (bcd),
        .o_dig_sel  (dig_sel),
        .o_carry    (carry),
        .o_load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        int             t;
        r = '0;
        t = v;
        for (int k = 0; k < N; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [4*N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[4*k +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [4*N-1:0] v);
        int r;
        r = 0;
        for (int k = N - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model update for one rising edge using the inputs sampled at that edge.
    task automatic model_edge();
        m_carry = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_val  = 0;
            m_tick = 0;
        end else begin
            m_tick++;
            if (load) begin
                if (is_bcd(load_val)) m_val = from_bcd(load_val);
                else m_err = 1'b1;
            end else if (en) begin
                if (up) begin
                    if (m_val == MAXV) begin
                        m_val = 0;
                        m_carry = 1'b1;
                    end else m_val++;
                end else begin
                    if (m_val == 0) begin
                        m_val = MAXV;
                        m_carry = 1'b1;
                    end else m_val--;
                end
            end
        end
    endtask

    task automatic step();
        int idx;
        int p;
        @(posedge clk);
        model_edge();
        #1;
        idx = (m_tick / SD) % N;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        chk("count", 32'(count), 32'(to_bcd(m_val)));
        chk("dig_sel", 32'(dig_sel), 32'(1) << idx);
        chk("bcd", 32'(bcd), 32'((m_val / p) % 10));
        chk("carry", 32'(carry), 32'(m_carry));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("bcd_legal", 32'(bcd <= 4'd9), 32'd1);
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [4*N-1:0] v);
        rst = r; en = e; up = u; load = l; load_val = v;
    endtask

    initial begin
        drive(1, 0, 1, 0, '0);
        #1;
        step();
        chk("rst_sel", 32'(dig_sel), 32'h1);

        drive(0, 1, 1, 0, '0);
        repeat (12) step();
        chk("up12", 32'(count), 32'h0012);

        drive(0, 0, 1, 1, 16'h9998);
        step();
        drive(0, 1, 1, 0, '0);
        step();
        chk("to9999", 32'(count), 32'h9999);
        step();
        chk("wrap_cnt", 32'(count), 32'h0000);
        chk("wrap_cy", 32'(carry), 32'd1);
        drive(0, 0, 1, 0, '0);
        step();
        chk("cy_1cyc", 32'(carry), 32'd0);

        drive(0, 0, 0, 1, 16'h0001);
        step();
        drive(0, 1, 0, 0, '0);
        step();
        chk("dn0", 32'(count), 32'h0000);
        step();
        chk("borrow", 32'(count), 32'h9999);
        chk("borrow_cy", 32'(carry), 32'd1);

        drive(0, 1, 1, 1, 16'h12A4);
        step();
        chk("bad_load_err", 32'(load_err), 32'd1);
        chk("bad_load_cnt", 32'(count), 32'h9999);
        drive(0, 0, 1, 0, '0);
        step();
        chk("err_1cyc", 32'(load_err), 32'd0);

        drive(0, 0, 1, 1, 16'h4321);
        step();
        drive(0, 0, 1, 0, '0);
        repeat (2 * N * SD) step();

        drive(0, 1, 1, 1, 16'h0500);
        step();
        chk("load_wins", 32'(count), 32'h0500);

        drive(0, 1, 1, 0, '0);
        repeat (5) step();
        drive(1, 1, 1, 0, '0);
        step();
        chk("mid_rst_cnt", 32'(count), 32'h0000);
        chk("mid_rst_sel", 32'(dig_sel), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            logic [4*N-1:0] v;
            if ($urandom_range(0, 1) == 0) v = to_bcd(int'($urandom_range(0, MAXV)));
            else v = 16'($urandom);
            // Bias values near the wrap points so carry/borrow gets exercised.
            if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 0) ? 16'h9997 : 16'h0002;
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0), v);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
